// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: execute-stage initiator for the multi-cycle multiply/divide unit.
// Latches operands, issues a one-cycle start pulse, stalls until the unit is
// ready, then presents a one-cycle writeback (status register on exception).
// Optional feature macro: MDCTRL_WATCHDOG_EN (WAIT-state timeout to exception).
module md_issue_ctrl #(
  parameter int unsigned MULT_EXC_CODE = 4,
  parameter int unsigned DIV_EXC_CODE  = 5,
  parameter int unsigned STATUS_REG    = 30
`ifdef MDCTRL_WATCHDOG_EN
  , parameter int unsigned TIMEOUT     = 48
`endif
) (
  input  logic        clock,
  input  logic        clrn,
  input  logic        ex_valid,
  input  logic        ex_is_mult,
  input  logic        ex_is_div,
  input  logic        ex_flush,
  input  logic [31:0] ex_a,
  input  logic [31:0] ex_b,
  input  logic [4:0]  ex_rd,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] WB    = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          op_mult_q, op_mult_d;
  logic [RW-1:0] rd_q, rd_d;
  logic [DW-1:0] opa_d, opb_d;
  logic          mult_d, div_d;
  logic          wb_valid_d;
  logic [RW-1:0] wb_rd_d;
  logic [DW-1:0] wb_data_d;
  logic          req;
  logic          done;
  logic          exc;

  // Flush in IDLE suppresses a new request in the same cycle
  assign req = ex_valid & (ex_is_mult | ex_is_div) & ~ex_flush;

`ifdef MDCTRL_WATCHDOG_EN
  localparam int unsigned CW = 6;
  logic [CW-1:0] wd_cnt_q, wd_cnt_d;
  logic          wd_expired;

  // Timeout after TIMEOUT consecutive WAIT cycles without ready
  assign wd_expired = (wd_cnt_q == CW'(TIMEOUT - 1));
  assign done       = md_resultRDY | wd_expired;
  assign exc        = md_resultRDY ? md_exception : 1'b1;
`else
  assign done = md_resultRDY;
  assign exc  = md_exception;
`endif

  // Pipeline freeze: request cycle, ISSUE and WAIT; released in WB
  assign stall = clrn & (((state_q == IDLE) & req) | (state_q == ISSUE) | (state_q == WAIT));

  // Next-state and next-output decode
  always_comb begin
    state_d    = state_q;
    op_mult_d  = op_mult_q;
    rd_d       = rd_q;
    opa_d      = '0;
    opb_d      = '0;
    mult_d     = 1'b0;
    div_d      = 1'b0;
    wb_valid_d = 1'b0;
    wb_rd_d    = '0;
    wb_data_d  = '0;
`ifdef MDCTRL_WATCHDOG_EN
    wd_cnt_d   = '0;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d   = ISSUE;
          op_mult_d = ex_is_mult;
          rd_d      = ex_rd;
          opa_d     = ex_a;
          opb_d     = ex_b;
          mult_d    = ex_is_mult;
          div_d     = ~ex_is_mult;
        end
      end
      ISSUE: begin
        // Ready is stale here (previous op), so always proceed to WAIT
        if (ex_flush) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          opa_d   = md_operandA;
          opb_d   = md_operandB;
        end
      end
      WAIT: begin
        if (ex_flush) begin
          state_d = IDLE;
        end else if (done) begin
          state_d    = WB;
          wb_valid_d = exc | (rd_q != '0);
          wb_rd_d    = exc ? RW'(STATUS_REG) : rd_q;
          wb_data_d  = exc ? (op_mult_q ? DW'(MULT_EXC_CODE) : DW'(DIV_EXC_CODE)) : md_result;
        end else begin
          opa_d = md_operandA;
          opb_d = md_operandB;
`ifdef MDCTRL_WATCHDOG_EN
          wd_cnt_d = wd_cnt_q + CW'(1);
`endif
        end
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latches and registered outputs
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state_q      <= IDLE;
      op_mult_q    <= 1'b0;
      rd_q         <= '0;
      md_operandA  <= '0;
      md_operandB  <= '0;
      md_ctrl_MULT <= 1'b0;
      md_ctrl_DIV  <= 1'b0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
`ifdef MDCTRL_WATCHDOG_EN
      wd_cnt_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      op_mult_q    <= op_mult_d;
      rd_q         <= rd_d;
      md_operandA  <= opa_d;
      md_operandB  <= opb_d;
      md_ctrl_MULT <= mult_d;
      md_ctrl_DIV  <= div_d;
      wb_valid     <= wb_valid_d;
      wb_rd        <= wb_rd_d;
      wb_data      <= wb_data_d;
`ifdef MDCTRL_WATCHDOG_EN
      wd_cnt_q     <= wd_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed testbench for md_issue_ctrl: the bench plays the mul/div unit with
// hand-picked results and checks the controller's handshake and writeback.
module tb_md_issue_ctrl;

  logic        clock;
  logic        clrn;
  logic        ex_valid, ex_is_mult, ex_is_div, ex_flush;
  logic [31:0] ex_a, ex_b;
  logic [4:0]  ex_rd;
  logic [31:0] md_operandA, md_operandB;
  logic        md_ctrl_MULT, md_ctrl_DIV;
  logic [31:0] md_result;
  logic        md_exception, md_resultRDY;
  logic        stall, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_cmp;
  int n_err;

  md_issue_ctrl dut (
    .clock(clock), .clrn(clrn),
    .ex_valid(ex_valid), .ex_is_mult(ex_is_mult), .ex_is_div(ex_is_div), .ex_flush(ex_flush),
    .ex_a(ex_a), .ex_b(ex_b), .ex_rd(ex_rd),
    .md_operandA(md_operandA), .md_operandB(md_operandB),
    .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
    .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
    .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to 1 time unit after the next rising edge (input drive point)
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_req(input logic m, input logic d, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd);
    ex_valid = 1'b1; ex_is_mult = m; ex_is_div = d; ex_a = a; ex_b = b; ex_rd = rd;
  endtask

  task automatic clear_req();
    ex_valid = 1'b0; ex_is_mult = 1'b0; ex_is_div = 1'b0; ex_a = '0; ex_b = '0; ex_rd = '0;
  endtask

  // From the ISSUE slot: n WAIT cycles, ready on the last, then land in the WB slot
  task automatic run_to_wb(input int n, input logic [31:0] res, input logic exc);
    for (int i = 0; i < n; i++) begin
      step();
      if (i == n - 1) begin
        md_resultRDY = 1'b1; md_result = res; md_exception = exc;
      end
      #2;
    end
    step();
    md_resultRDY = 1'b0; md_exception = 1'b0;
    #2;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b expected 0", stall); end
    n_cmp++; if ({md_ctrl_MULT, md_ctrl_DIV} !== 2'b00) begin n_err++; $display("FAIL reset_ctrl: got %b expected 00", {md_ctrl_MULT, md_ctrl_DIV}); end
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL reset_wb_valid: got %b expected 0", wb_valid); end
    n_cmp++; if (wb_rd !== 5'd0 || wb_data !== 32'd0) begin n_err++; $display("FAIL reset_wb: got rd=%0d data=%h expected 0/0", wb_rd, wb_data); end
    n_cmp++; if (md_operandA !== 32'd0 || md_operandB !== 32'd0) begin n_err++; $display("FAIL reset_operands: got %h/%h expected 0/0", md_operandA, md_operandB); end
    step();
    step();
    clrn = 1'b1;
  endtask

  task automatic test_mult();
    logic ok;
    step();
    drive_req(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 5'd5);
    #2;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL mult_req_stall: got %b expected 1", stall); end
    step(); clear_req(); #2;
    n_cmp++; if ({md_ctrl_MULT, md_ctrl_DIV} !== 2'b10) begin n_err++; $display("FAIL mult_issue_pulse: got %b expected 10", {md_ctrl_MULT, md_ctrl_DIV}); end
    n_cmp++; if (md_operandA !== 32'd7 || md_operandB !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL mult_issue_operands: got %h/%h expected 00000007/fffffffd", md_operandA, md_operandB); end
    ok = 1'b1;
    for (int i = 0; i < 33; i++) begin
      step();
      if (i == 32) begin md_resultRDY = 1'b1; md_result = 32'hFFFF_FFEB; md_exception = 1'b0; end
      #2;
      if (md_operandA !== 32'd7 || md_operandB !== 32'hFFFF_FFFD || md_ctrl_MULT !== 1'b0 ||
          stall !== 1'b1 || wb_valid !== 1'b0) ok = 1'b0;
    end
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL mult_wait_hold: got ok=%b expected 1", ok); end
    step(); #2;
    n_cmp++; if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mult_wb: got v=%b rd=%0d data=%h expected 1/5/ffffffeb", wb_valid, wb_rd, wb_data); end
    n_cmp++; if (stall !== 1'b0 || md_operandA !== 32'd0) begin n_err++; $display("FAIL mult_wb_release: got stall=%b opA=%h expected 0/0", stall, md_operandA); end
  endtask

  // Entered from the MULT's WB slot with md_resultRDY still high
  task automatic test_back_to_back();
    step();
    drive_req(1'b0, 1'b1, 32'd100, 32'd7, 5'd9);
    #2;
    n_cmp++; if (wb_valid !== 1'b0 || stall !== 1'b1) begin n_err++; $display("FAIL b2b_bubble: got v=%b stall=%b expected 0/1", wb_valid, stall); end
    step(); clear_req(); #2;
    n_cmp++; if ({md_ctrl_MULT, md_ctrl_DIV} !== 2'b01 || md_operandA !== 32'd100 || md_operandB !== 32'd7) begin n_err++; $display("FAIL b2b_div_issue: got ctrl=%b a=%0d b=%0d expected 01/100/7", {md_ctrl_MULT, md_ctrl_DIV}, md_operandA, md_operandB); end
    step(); md_resultRDY = 1'b0; #2;
    n_cmp++; if (wb_valid !== 1'b0 || stall !== 1'b1 || md_ctrl_DIV !== 1'b0) begin n_err++; $display("FAIL b2b_stale_ready: got v=%b stall=%b div=%b expected 0/1/0", wb_valid, stall, md_ctrl_DIV); end
    run_to_wb(32, 32'd14, 1'b0);
    n_cmp++; if (wb_valid !== 1'b1 || wb_rd !== 5'd9 || wb_data !== 32'd14) begin n_err++; $display("FAIL div_wb: got v=%b rd=%0d data=%h expected 1/9/0000000e", wb_valid, wb_rd, wb_data); end
    step(); #2;
    n_cmp++; if (wb_valid !== 1'b0 || stall !== 1'b0) begin n_err++; $display("FAIL div_after_wb: got v=%b stall=%b expected 0/0", wb_valid, stall); end
  endtask

  task automatic test_exceptions();
    step(); drive_req(1'b0, 1'b1, 32'd12, 32'd0, 5'd4);
    step(); clear_req();
    run_to_wb(33, 32'hDEAD_BEEF, 1'b1);
    n_cmp++; if (wb_valid !== 1'b1 || wb_rd !== 5'd30 || wb_data !== 32'd5) begin n_err++; $display("FAIL div_exc_wb: got v=%b rd=%0d data=%h expected 1/30/00000005", wb_valid, wb_rd, wb_data); end
    ex_flush = 1'b1;
    step(); ex_flush = 1'b0;
    drive_req(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd2, 5'd6);
    #2;
    n_cmp++; if (wb_valid !== 1'b0 || stall !== 1'b1) begin n_err++; $display("FAIL wb_flush_noeffect: got v=%b stall=%b expected 0/1", wb_valid, stall); end
    step(); clear_req();
    run_to_wb(33, 32'hFFFF_FFFE, 1'b1);
    n_cmp++; if (wb_valid !== 1'b1 || wb_rd !== 5'd30 || wb_data !== 32'd4) begin n_err++; $display("FAIL mult_exc_wb: got v=%b rd=%0d data=%h expected 1/30/00000004", wb_valid, wb_rd, wb_data); end
  endtask

  task automatic test_rd_zero();
    step(); drive_req(1'b1, 1'b1, 32'd2, 32'd3, 5'd0);
    step(); clear_req(); #2;
    n_cmp++; if ({md_ctrl_MULT, md_ctrl_DIV} !== 2'b10) begin n_err++; $display("FAIL both_flags_mult_wins: got %b expected 10", {md_ctrl_MULT, md_ctrl_DIV}); end
    run_to_wb(10, 32'd6, 1'b0);
    n_cmp++; if (wb_valid !== 1'b0 || stall !== 1'b0) begin n_err++; $display("FAIL rd0_wb: got v=%b stall=%b expected 0/0", wb_valid, stall); end
  endtask

  task automatic test_flush();
    logic ok;
    step(); drive_req(1'b1, 1'b0, 32'd5, 32'd6, 5'd8);
    step(); clear_req();
    for (int i = 0; i < 10; i++) step();
    ex_flush = 1'b1; #2;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL flush_cycle_stall: got %b expected 1", stall); end
    step(); ex_flush = 1'b0; md_resultRDY = 1'b1; md_result = 32'd30; #2;
    n_cmp++; if (stall !== 1'b0 || wb_valid !== 1'b0 || md_operandA !== 32'd0) begin n_err++; $display("FAIL flush_idle: got stall=%b v=%b opA=%h expected 0/0/0", stall, wb_valid, md_operandA); end
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin step(); #2; if (wb_valid !== 1'b0 || stall !== 1'b0) ok = 1'b0; end
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL flush_late_ready: got ok=%b expected 1", ok); end
    drive_req(1'b1, 1'b0, 32'd3, 32'd4, 5'd7); ex_flush = 1'b1; #2;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL idle_flush_blocks: got stall=%b expected 0", stall); end
    step(); ex_flush = 1'b0; #2;
    n_cmp++; if (md_ctrl_MULT !== 1'b0) begin n_err++; $display("FAIL idle_flush_no_issue: got %b expected 0", md_ctrl_MULT); end
    step(); clear_req(); md_resultRDY = 1'b0; #2;
    n_cmp++; if (md_ctrl_MULT !== 1'b1 || md_operandA !== 32'd3 || md_operandB !== 32'd4) begin n_err++; $display("FAIL reissue: got mult=%b a=%0d b=%0d expected 1/3/4", md_ctrl_MULT, md_operandA, md_operandB); end
    run_to_wb(33, 32'd12, 1'b0);
    n_cmp++; if (wb_valid !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 32'd12) begin n_err++; $display("FAIL reissue_wb: got v=%b rd=%0d data=%h expected 1/7/0000000c", wb_valid, wb_rd, wb_data); end
  endtask

  task automatic test_async_reset();
    step(); drive_req(1'b0, 1'b1, 32'd55, 32'd5, 5'd11);
    step(); clear_req();
    for (int i = 0; i < 5; i++) step();
    clrn = 1'b0; #1;
    n_cmp++; if (stall !== 1'b0 || md_operandA !== 32'd0 || md_operandB !== 32'd0) begin n_err++; $display("FAIL areset_outputs: got stall=%b a=%h b=%h expected 0/0/0", stall, md_operandA, md_operandB); end
    n_cmp++; if (wb_valid !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0 || md_ctrl_DIV !== 1'b0) begin n_err++; $display("FAIL areset_wb: got v=%b rd=%0d data=%h div=%b expected zeros", wb_valid, wb_rd, wb_data, md_ctrl_DIV); end
    step(); clrn = 1'b1; md_resultRDY = 1'b1; md_result = 32'd11;
    step(); step(); #2;
    n_cmp++; if (wb_valid !== 1'b0 || stall !== 1'b0) begin n_err++; $display("FAIL areset_idle: got v=%b stall=%b expected 0/0", wb_valid, stall); end
    md_resultRDY = 1'b0;
  endtask

  task automatic test_long_wait();
    int cnt;
    step(); drive_req(1'b1, 1'b0, 32'd1, 32'd2, 5'd3);
    step(); clear_req();
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step(); #2;
      if (wb_valid === 1'b1) break;
      cnt++;
    end
`ifdef MDCTRL_WATCHDOG_EN
    n_cmp++; if (cnt !== 48) begin n_err++; $display("FAIL wd_wait_len: got %0d expected 48", cnt); end
    n_cmp++; if (wb_rd !== 5'd30 || wb_data !== 32'd4) begin n_err++; $display("FAIL wd_wb: got rd=%0d data=%h expected 30/00000004", wb_rd, wb_data); end
`else
    n_cmp++; if (cnt !== 100 || stall !== 1'b1) begin n_err++; $display("FAIL no_wd_wait: got cnt=%0d stall=%b expected 100/1", cnt, stall); end
    ex_flush = 1'b1;
    step(); ex_flush = 1'b0; #2;
    n_cmp++; if (stall !== 1'b0 || wb_valid !== 1'b0) begin n_err++; $display("FAIL no_wd_flush: got stall=%b v=%b expected 0/0", stall, wb_valid); end
`endif
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    clrn = 1'b0;
    ex_flush = 1'b0;
    clear_req();
    md_result = '0; md_exception = 1'b0; md_resultRDY = 1'b0;
    test_reset();
    test_mult();
    test_back_to_back();
    test_exceptions();
    test_rd_zero();
    test_flush();
    test_async_reset();
    test_long_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/md_issue_ctrl.md
# md_issue_ctrl

Processor-side initiator for the multi-cycle multiply/divide unit. Sits in the execute stage. On a MULT/DIV instruction it:
- latches the operands and holds them stable for the whole operation;
- issues a single-cycle start pulse;
- stalls the pipeline until the unit reports ready;
- presents a one-cycle register-file writeback, redirecting to the status register on exception.

## Interface
Parameters:
- MULT_EXC_CODE, 4, value written to status register on multiply exception
- DIV_EXC_CODE, 5, value written to status register on divide exception
- STATUS_REG, 30, register index receiving exception codes
- TIMEOUT, 48, WAIT-state cycle limit (used only with MDCTRL_WATCHDOG_EN)

Ports:
- clock  in  1  single clock, rising edge
- clrn  in  1  asynchronous, active-low reset
- ex_valid  in  1  execute-stage instruction valid
- ex_is_mult  in  1  instruction is MULT
- ex_is_div  in  1  instruction is DIV
- ex_flush  in  1  kill in-flight op
- ex_a  in  32  rs operand value
- ex_b  in  32  rt operand value
- ex_rd  in  5  destination register
- md_operandA  out  32  held operand A to unit
- md_operandB  out  32  held operand B to unit
- md_ctrl_MULT  out  1  multiply start pulse
- md_ctrl_DIV  out  1  divide start pulse
- md_result  in  32  unit result
- md_exception  in  1  unit exception flag
- md_resultRDY  in  1  unit ready level
- stall  out  1  freeze upstream pipeline
- wb_valid  out  1  writeback strobe
- wb_rd  out  5  writeback register
- wb_data  out  32  writeback value

## Operation
FSM states: IDLE, ISSUE, WAIT, WB.

**IDLE**
- A request is ex_valid & (ex_is_mult | ex_is_div).
- On a request, latch ex_a/ex_b/ex_rd and op, then go to ISSUE.
- If both op flags are set, MULT wins.
- stall is asserted combinationally in the request cycle.

**ISSUE** (exactly 1 cycle)
- Assert md_ctrl_MULT or md_ctrl_DIV, never both.
- md_resultRDY is ignored: it still reflects the previous operation.
- Go to WAIT.

**WAIT**
- On md_resultRDY=1, capture md_result and md_exception, then go to WB.

**WB** (exactly 1 cycle)
- wb_valid=1, then go to IDLE.
- Exception: wb_rd=STATUS_REG; wb_data=MULT_EXC_CODE or DIV_EXC_CODE per latched op.
- Otherwise: wb_rd=latched rd; wb_data=captured result.
- wb_valid is forced 0 when there is no exception and latched rd==0.

**Operand holding**
- md_operandA/B drive the latched values from ISSUE through the end of WAIT.
- The unit samples them on every cycle, so they must not change before WB.
- In IDLE and WB they are 0.

**Stall**
- stall=1 in ISSUE and WAIT, and in IDLE when a request is present.
- stall=0 in WB, so the pipeline advances at the end of WB.
- The held instruction is never re-issued: the FSM is not in IDLE during WB.

**Flush**
- ex_flush in ISSUE or WAIT: go to IDLE next edge, with no WB and stall dropped.
- The unit's later result is ignored; the next ISSUE restarts it.
- ex_flush in IDLE blocks a new request that cycle.
- ex_flush in WB has no effect.

**Reset**
- clrn low: state=IDLE immediately.
- All outputs 0 and all latches cleared, including mid-operation.
- The unit has no reset; the next start pulse restarts it cleanly.

## Timing
- Unit ready arrives about 33 cycles after the start-pulse edge.
- Stall length = 1 (request) + 1 (ISSUE) + WAIT cycles; WB is the first non-stalled cycle.
- Ready sampled in WAIT at edge N produces wb_valid during cycle N+1.
- Back-to-back ops: the second request is seen in IDLE the cycle after WB, so there is a 1-cycle bubble minimum.
- Reset values: stall=0, md_ctrl_*=0, wb_valid=0, wb_rd=0, wb_data=0, md_operand*=0.

## Configuration
- MDCTRL_WATCHDOG_EN defined:
  - a 6-bit counter runs in WAIT;
  - if it reaches TIMEOUT without md_resultRDY, go to WB as an exception (code per op);
  - the counter clears on leaving WAIT.
- Not defined: no counter; WAIT persists until md_resultRDY or flush.

## Test plan
- MULT a=7, b=-3, rd=5: one md_ctrl_MULT pulse. Operands stable until WB; then wb_rd=5, wb_data=0xFFFFFFEB, wb_valid for 1 cycle.
- DIV a=100, b=7, rd=9, issued directly after a completed MULT (stale md_resultRDY=1): no completion in ISSUE; wb_rd=9, wb_data=14.
- DIV a=12, b=0 (unit exception) -> wb_rd=30, wb_data=5. MULT 0x7FFFFFFF×2 overflow -> wb_rd=30, wb_data=4.
- MULT with rd=0, no exception -> wb_valid stays 0; stall still releases in the WB cycle.
- ex_flush 10 cycles into WAIT -> IDLE next edge, stall=0, no wb_valid. A subsequent MULT 3×4 writes 12.
- clrn pulsed low mid-WAIT -> all outputs 0 immediately. With MDCTRL_WATCHDOG_EN, holding md_resultRDY=0 gives wb_rd=30 after TIMEOUT cycles.
